// File: rtl/stk_pkg.sv
// Shared widths and pointer layout for the stack engines.
// A pointer is {bank, line}; the bank sits in the upper bits.
package stk_pkg;
  localparam int unsigned BANKS_N        = 4;
  localparam int unsigned C_BANK_LINES_N = 1024;
  localparam int unsigned BNK_W          = $clog2(BANKS_N);
  localparam int unsigned LINE_W         = $clog2(C_BANK_LINES_N);
  localparam int unsigned ENGID_W        = 4;

  typedef logic [BNK_W-1:0]   bnk_id_t;
  typedef logic [LINE_W-1:0]  line_id_t;
  typedef logic [ENGID_W-1:0] engid_t;
  typedef logic [LINE_W:0]    top_t;

  typedef struct packed {
    bnk_id_t  bnk_id;
    line_id_t line_id;
  } ptr_t;
endpackage

// File: rtl/stk_ptr_alloc.sv
// Free-line allocator: one free stack per bank and round-robin bank selection.
// Allocation responses come one cycle after accept; releases push lines back.
module stk_ptr_alloc
  import stk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req_vld,
  input  engid_t      alloc_req_engid,
  output logic        alloc_req_rdy,
  output logic        alloc_rsp_vld,
  output engid_t      alloc_rsp_engid,
  output ptr_t        alloc_rsp_ptr,
  input  logic        free_vld,
  input  ptr_t        free_ptr,
  output logic        free_rdy,
  output logic        init_done,
  output logic [12:0] free_cnt,
  output logic        err_dbl_free
);
  typedef enum logic {S_INIT, S_READY} state_e;

  state_e      state_q;
  line_id_t    init_i_q;
  logic        init_done_q;
  top_t        top_q [BANKS_N];
  bnk_id_t     rr_q;
  line_id_t    mem_q [BANKS_N][C_BANK_LINES_N];
  logic        rsp_vld_q;
  engid_t      rsp_engid_q;
  ptr_t        rsp_ptr_q;
  logic        err_q;
  logic [12:0] free_cnt_q;

  logic [BANKS_N-1:0] has_free;
  bnk_id_t            grant;
  bnk_id_t            cand;
  logic               alloc_acc;
  logic               free_acc;
  logic               free_full;
  logic               free_ok;
  logic               same_bank;
  line_id_t           rd_idx;
  top_t               top_d [BANKS_N];
  logic [12:0]        cnt_sum;

  always_comb begin
    has_free = '0;
    grant    = rr_q;
    cand     = '0;
    cnt_sum  = '0;
    for (int unsigned k = 0; k < BANKS_N; k++) begin
      has_free[k] = (top_q[k] != '0);
      cnt_sum     = cnt_sum + {2'b00, top_q[k]};
    end
    // Descending scan so the candidate closest to rr wins.
    for (int unsigned k = BANKS_N; k > 0; k--) begin
      cand = rr_q + bnk_id_t'(k - 1);
      if (has_free[cand]) grant = cand;
    end
  end

  assign alloc_req_rdy = init_done_q & (|has_free);
  assign free_rdy      = init_done_q;
  assign alloc_acc     = alloc_req_vld & alloc_req_rdy;
  assign free_acc      = free_vld & free_rdy;
  assign free_full     = (top_q[free_ptr.bnk_id] == top_t'(C_BANK_LINES_N));
  assign free_ok       = free_acc & ~free_full;
  assign same_bank     = alloc_acc & free_ok & (grant == free_ptr.bnk_id);
  // top is 1..1024 when granted, so the low bits minus one wrap to the right index.
  assign rd_idx        = top_q[grant][LINE_W-1:0] - line_id_t'(1);

  always_comb begin
    for (int unsigned b = 0; b < BANKS_N; b++) begin
      top_d[b] = top_q[b];
      if (alloc_acc && grant == bnk_id_t'(b) && !(free_ok && free_ptr.bnk_id == bnk_id_t'(b)))
        top_d[b] = top_q[b] - top_t'(1);
      if (free_ok && free_ptr.bnk_id == bnk_id_t'(b) && !(alloc_acc && grant == bnk_id_t'(b)))
        top_d[b] = top_q[b] + top_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      for (int unsigned b = 0; b < BANKS_N; b++) mem_q[b][init_i_q] <= init_i_q;
    end
    if (free_ok && !same_bank)
      mem_q[free_ptr.bnk_id][top_q[free_ptr.bnk_id][LINE_W-1:0]] <= free_ptr.line_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_i_q    <= '0;
      init_done_q <= 1'b0;
      for (int unsigned b = 0; b < BANKS_N; b++) top_q[b] <= '0;
      rr_q        <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_engid_q <= '0;
      rsp_ptr_q   <= '0;
      err_q       <= 1'b0;
      free_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_i_q <= init_i_q + line_id_t'(1);
          if (init_i_q == '1) begin
            state_q     <= S_READY;
            init_done_q <= 1'b1;
            for (int unsigned b = 0; b < BANKS_N; b++) top_q[b] <= top_t'(C_BANK_LINES_N);
          end
        end
        S_READY: begin
          for (int unsigned b = 0; b < BANKS_N; b++) top_q[b] <= top_d[b];
        end
        default: state_q <= S_INIT;
      endcase
      rsp_vld_q <= alloc_acc;
      if (alloc_acc) begin
        rsp_engid_q       <= alloc_req_engid;
        rsp_ptr_q.bnk_id  <= grant;
        // A same-bank release is handed straight back instead of touching the stack.
        rsp_ptr_q.line_id <= same_bank ? free_ptr.line_id : mem_q[grant][rd_idx];
        rr_q              <= grant + bnk_id_t'(1);
      end
      if (free_acc && free_full) err_q <= 1'b1;
      free_cnt_q <= cnt_sum;
    end
  end

  assign alloc_rsp_vld   = rsp_vld_q;
  assign alloc_rsp_engid = rsp_engid_q;
  assign alloc_rsp_ptr   = rsp_ptr_q;
  assign init_done       = init_done_q;
  assign free_cnt        = free_cnt_q;
  assign err_dbl_free    = err_q;
endmodule

// File: doc/stk_ptr_alloc.md
# stk_ptr_alloc

Free-line allocator for the stack engines. Owns the free pool of every SRAM line across all banks. Hands out `ptr_t` pointers, allocating round-robin across banks, when an engine needs storage for a PUSH. Takes pointers back when an engine releases a line on POP. Sits between the engine array (requester and releaser) and the banked line SRAMs (consumer of the returned pointers). Widths come from `stk_pkg`.

## Interface
Parameters (all fixed by `stk_pkg`; not overridable):
- `BANKS_N`, 4: number of banks.
- `C_BANK_LINES_N`, 1024: lines per bank.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_req_vld`  in  1  allocation request.
- `alloc_req_engid`  in  `engid_t`  requesting engine.
- `alloc_req_rdy`  out  1  request accepted when vld & rdy.
- `alloc_rsp_vld`  out  1  response valid, 1-cycle pulse, no backpressure.
- `alloc_rsp_engid`  out  `engid_t`  echo of the requesting engine.
- `alloc_rsp_ptr`  out  `ptr_t`  allocated pointer.
- `free_vld`  in  1  release request.
- `free_ptr`  in  `ptr_t`  pointer being released.
- `free_rdy`  out  1  release accepted when vld & rdy.
- `init_done`  out  1  pool initialised.
- `free_cnt`  out  13  total free lines, range 0..4096.
- `err_dbl_free`  out  1  sticky; set on a release to a full bank.

## Operation
- Per bank: one free-stack memory of 1024 x `line_id_t` with a synchronous read, plus `top[b]` (11 bits, 0..1024), the count of free lines in that bank.
- FSM states:
  - INIT: entered on `rst`. A 10-bit counter `i` writes `mem[b][i] = i` in all banks in parallel. After the write at `i = 1023`, set every `top[b] = 1024` and go to READY.
  - READY: terminal state. Left only via `rst`.
- Bank select:
  - Round-robin pointer `rr` (2 bits, reset 0).
  - Grant the first bank with `top != 0`, searching `rr, rr+1, ...` modulo 4.
  - On an accepted request, `rr` becomes granted bank + 1 (modulo 4, wraps 3 -> 0).
- Allocation accept in cycle N:
  - Read `mem[g][top[g]-1]`.
  - Decrement `top[g]`.
  - Capture `g` and `engid` for the response.
- Release accept:
  - Write `free_ptr.line_id` to `mem[free_ptr.bnk_id][top]`.
  - Increment that bank's `top`.
  - If that bank's `top == 1024`: drop the write, leave `top` unchanged, set `err_dbl_free`.
- Simultaneous allocate and release to the same bank in the same cycle:
  - `top` is unchanged.
  - No memory write.
  - The response returns the released `line_id` (forwarded), not the memory read data.
- Simultaneous allocate and release to different banks: both proceed independently.
- Bank select uses the `top` values at the start of the cycle. A bank with `top == 0` is never granted, even if a release to it lands in the same cycle.
- `free_cnt` is the sum of `top[0..3]`, registered. It updates 1 cycle after each accept.

## Timing
- Reset values:
  - `alloc_req_rdy`, `free_rdy`, `alloc_rsp_vld`, `init_done`, `err_dbl_free`: 0.
  - `free_cnt`: 0.
  - `alloc_rsp_ptr`, `alloc_rsp_engid`: 0.
- INIT lasts exactly 1024 cycles after the first cycle with `rst` low. `init_done`, `alloc_req_rdy` and `free_rdy` are 0 throughout INIT.
- `alloc_req_rdy = init_done & (any top[b] != 0)`. It is combinational from state and does not depend on `alloc_req_vld`.
- `free_rdy = init_done`.
- Allocation latency: 1 cycle. Accept at edge N gives `alloc_rsp_vld = 1` during cycle N+1.
- Throughput: 1 allocation plus 1 release per cycle.
- `rst` asserted mid-operation:
  - Any pending response is discarded (`alloc_rsp_vld = 0` the next cycle).
  - All counts are cleared.
  - INIT restarts from `i = 0`.
  - `err_dbl_free` clears only on `rst`.

## Test plan
- Reset, then idle: `init_done` rises exactly 1024 cycles after `rst` falls, with `free_cnt` = 4096 one cycle later. Requests presented during INIT see `rdy = 0` and produce no response.
- Back-to-back allocations from engid 5: responses in order 0x3FF, 0x7FF, 0xBFF, 0xFFF, 0x3FE, each 1 cycle after its accept, each with `alloc_rsp_engid = 5`.
- Allocate all 4096 lines: after the last accept, `alloc_req_rdy = 0` and `free_cnt = 0`. A release of 0x123 re-raises `alloc_req_rdy`, and the next allocation returns 0x123.
- With `rr` = 0 and bank 0 at `top` = 5, allocate while releasing 0x07B (bank 0, line 123) in the same cycle: response ptr = 0x07B, bank 0 `top` stays 5, `free_cnt` unchanged.
- Release 0x400 (bank 1) while bank 1 is full: `err_dbl_free` rises and stays 1, `free_cnt` unchanged. Assert `rst`: `err_dbl_free` = 0 and INIT restarts.
- Assert `rst` in the cycle after an allocation accept: `alloc_rsp_vld` = 0 the next cycle, and the full 1024-cycle INIT sequence repeats.
